// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state encoding and default bus widths shared by the arbiter and its interface
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-0/1 and memory-side signals of the arbiter; master is the arbiter view
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
);

    logic              p0_enable_i;
    logic              p0_write_i;
    logic [ADDR_W-1:0] p0_addr_i;
    logic [LINE_W-1:0] p0_data_i;
    logic [LINE_W-1:0] p0_data_o;
    logic              p0_ack_o;

    logic              p1_enable_i;
    logic              p1_write_i;
    logic [ADDR_W-1:0] p1_addr_i;
    logic [LINE_W-1:0] p1_data_i;
    logic [LINE_W-1:0] p1_data_o;
    logic              p1_ack_o;

    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;

    logic [1:0]        grant_o;

    modport master (
        input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
        output p0_data_o, p0_ack_o,
        input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
        output p1_data_o, p1_ack_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i,
        output grant_o
    );

    modport slave (
        output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
        input  p0_data_o, p0_ack_o,
        output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
        input  p1_data_o, p1_ack_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i,
        input  grant_o
    );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (dcache/icache) arbiter for one data memory; define ARB_ROUND_ROBIN_EN for round-robin ties, else p0 wins ties
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
)(
    input  logic         clk_i,
    input  logic         rst_i,
    mem_arbiter_if.master bus
);

    state_t state;
    state_t state_next;
    logic   pick1;
    logic   sel0;
    logic   sel1;

`ifdef ARB_ROUND_ROBIN_EN
    logic last;

    // remember who owned the memory last; reset value 1 makes p0 win the first tie
    always_ff @(posedge clk_i) begin
        if (rst_i)
            last <= 1'b1;
        else if (state != IDLE && state_next == IDLE)
            last <= (state == BUSY1);
    end

    assign pick1 = bus.p1_enable_i && (!bus.p0_enable_i || !last);
`else
    assign pick1 = bus.p1_enable_i && !bus.p0_enable_i;
`endif

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    // grant from IDLE, release on ack or when the owner drops its request
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.p0_enable_i || bus.p1_enable_i) state_next = pick1 ? BUSY1 : BUSY0;
            BUSY0:   if (bus.mem_ack_i || !bus.p0_enable_i) state_next = IDLE;
            BUSY1:   if (bus.mem_ack_i || !bus.p1_enable_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // reset masks ownership immediately so an in-flight ack is never forwarded
    assign sel0 = (state == BUSY0) && !rst_i;
    assign sel1 = (state == BUSY1) && !rst_i;

    // owner's request passes straight through to memory, unlatched
    always_comb begin
        bus.mem_enable_o = sel0 ? bus.p0_enable_i : sel1 ? bus.p1_enable_i : 1'b0;
        bus.mem_write_o  = sel0 ? bus.p0_write_i  : sel1 ? bus.p1_write_i  : 1'b0;
        bus.mem_addr_o   = sel0 ? bus.p0_addr_i   : sel1 ? bus.p1_addr_i   : ADDR_W'(0);
        bus.mem_data_o   = sel0 ? bus.p0_data_i   : sel1 ? bus.p1_data_i   : LINE_W'(0);
        bus.p0_ack_o     = sel0 && bus.mem_ack_i;
        bus.p1_ack_o     = sel1 && bus.mem_ack_i;
        bus.p0_data_o    = bus.mem_data_i;
        bus.p1_data_o    = bus.mem_data_i;
        bus.grant_o      = {sel1, sel0};
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against a transaction-level owner model
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit rr = 1'b1;
`else
    localparam bit rr = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   owner;
    int   last;
    logic [255:0] a5 = {32{8'hA5}};

    mem_arbiter_if #(.ADDR_W(32), .LINE_W(256)) bus ();

    mem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic zero_inputs();
        bus.p0_enable_i = 0; bus.p0_write_i = 0; bus.p0_addr_i = '0; bus.p0_data_i = '0;
        bus.p1_enable_i = 0; bus.p1_write_i = 0; bus.p1_addr_i = '0; bus.p1_data_i = '0;
        bus.mem_ack_i = 0;   bus.mem_data_i = '0;
    endtask

    task automatic model_edge();
        if (rst) begin
            owner = -1;
            last = 1;
        end else if (owner < 0) begin
            if (bus.p0_enable_i && bus.p1_enable_i) owner = rr ? (last == 0 ? 1 : 0) : 0;
            else if (bus.p0_enable_i) owner = 0;
            else if (bus.p1_enable_i) owner = 1;
        end else if (bus.mem_ack_i || !(owner == 0 ? bus.p0_enable_i : bus.p1_enable_i)) begin
            last = owner;
            owner = -1;
        end
    endtask

    task automatic probe(input string tag);
        int o;
        @(negedge clk);
        o = rst ? -1 : owner;
        chk({tag, ".grant"}, bus.grant_o, o == 0 ? 2'b01 : o == 1 ? 2'b10 : 2'b00);
        chk({tag, ".men"}, bus.mem_enable_o, o == 0 ? bus.p0_enable_i : o == 1 ? bus.p1_enable_i : 1'b0);
        chk({tag, ".mwr"}, bus.mem_write_o, o == 0 ? bus.p0_write_i : o == 1 ? bus.p1_write_i : 1'b0);
        chk({tag, ".maddr"}, bus.mem_addr_o, o == 0 ? bus.p0_addr_i : o == 1 ? bus.p1_addr_i : 32'd0);
        chk({tag, ".mdata"}, bus.mem_data_o, o == 0 ? bus.p0_data_i : o == 1 ? bus.p1_data_i : 256'd0);
        chk({tag, ".ack0"}, bus.p0_ack_o, o == 0 && bus.mem_ack_i);
        chk({tag, ".ack1"}, bus.p1_ack_o, o == 1 && bus.mem_ack_i);
        chk({tag, ".d0"}, bus.p0_data_o, bus.mem_data_i);
        chk({tag, ".d1"}, bus.p1_data_o, bus.mem_data_i);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        zero_inputs();
        bus.mem_data_i = {8{32'hDEAD_BEEF}};
        probe("rst");
        chk("rst.d0_follow", bus.p0_data_o, {8{32'hDEAD_BEEF}});
        tick();
        probe("rst2");
        tick();
        rst = 0;
    endtask

    initial begin
        logic [1:0] tie_exp [3];
        owner = -1;
        last = 1;
        do_reset();

        // lone p0 read of 0x400
        bus.p0_enable_i = 1; bus.p0_addr_i = 32'h0000_0400;
        probe("r29a"); chk("r29a.idle", bus.grant_o, 2'b00); tick();
        probe("r29b"); chk("r29b.grant", bus.grant_o, 2'b01); chk("r29b.addr", bus.mem_addr_o, 32'h400);
        chk("r29b.men", bus.mem_enable_o, 1'b1); tick();
        bus.mem_ack_i = 1; bus.mem_data_i = {8{32'h1234_5678}};
        probe("r29c"); chk("r29c.ack0", bus.p0_ack_o, 1'b1); chk("r29c.ack1", bus.p1_ack_o, 1'b0); tick();
        zero_inputs();
        probe("r29d"); chk("r29d.grant", bus.grant_o, 2'b00); tick();

        // ties: three back-to-back with both requesters held
        do_reset();
        tie_exp[0] = 2'b01;
        tie_exp[1] = rr ? 2'b10 : 2'b01;
        tie_exp[2] = 2'b01;
        bus.p0_enable_i = 1; bus.p0_addr_i = 32'h100;
        bus.p1_enable_i = 1; bus.p1_addr_i = 32'h200;
        for (int i = 0; i < 3; i++) begin
            bus.mem_ack_i = 0;
            probe("tie_idle"); chk("tie_idle.grant", bus.grant_o, 2'b00); tick();
            bus.mem_ack_i = 1;
            probe("tie_busy"); chk($sformatf("tie%0d.winner", i), bus.grant_o, tie_exp[i]); tick();
        end
        zero_inputs();
        probe("tie_end"); tick();

        // writeback then refill from the same port
        bus.p0_enable_i = 1; bus.p0_write_i = 1; bus.p0_addr_i = 32'h800; bus.p0_data_i = a5;
        probe("wb_idle"); tick();
        bus.mem_ack_i = 1;
        probe("wb_busy"); chk("wb.mdata", bus.mem_data_o, a5); chk("wb.mwr", bus.mem_write_o, 1'b1);
        chk("wb.ack0", bus.p0_ack_o, 1'b1); tick();
        bus.mem_ack_i = 0; bus.p0_write_i = 0;
        probe("rf_gap"); chk("rf_gap.grant", bus.grant_o, 2'b00); tick();
        probe("rf_busy"); chk("rf.grant", bus.grant_o, 2'b01); chk("rf.mwr", bus.mem_write_o, 1'b0); tick();
        bus.mem_ack_i = 1;
        probe("rf_ack"); tick();
        zero_inputs();
        probe("rf_end"); tick();

        // reset during BUSY1 swallows the ack
        bus.p1_enable_i = 1; bus.p1_addr_i = 32'hC00;
        probe("r33a"); tick();
        probe("r33b"); chk("r33b.grant", bus.grant_o, 2'b10); tick();
        rst = 1; bus.mem_ack_i = 1;
        probe("r33c"); chk("r33c.ack1", bus.p1_ack_o, 1'b0); tick();
        rst = 0; bus.p1_enable_i = 0;
        probe("r33d"); chk("r33d.grant", bus.grant_o, 2'b00); chk("r33d.men", bus.mem_enable_o, 1'b0);
        chk("r33d.ack1", bus.p1_ack_o, 1'b0); tick();
        zero_inputs();

        // p0 aborts, pending p1 then granted
        bus.p0_enable_i = 1; bus.p0_addr_i = 32'h40;
        probe("r34a"); tick();
        bus.p1_enable_i = 1; bus.p1_addr_i = 32'h80;
        probe("r34b"); chk("r34b.grant", bus.grant_o, 2'b01); tick();
        bus.p0_enable_i = 0;
        probe("r34c"); chk("r34c.men", bus.mem_enable_o, 1'b0); tick();
        probe("r34d"); chk("r34d.grant", bus.grant_o, 2'b00); tick();
        probe("r34e"); chk("r34e.grant", bus.grant_o, 2'b10); chk("r34e.addr", bus.mem_addr_o, 32'h80); tick();
        bus.mem_ack_i = 1;
        probe("r34f"); chk("r34f.ack1", bus.p1_ack_o, 1'b1); tick();
        zero_inputs();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            bus.p0_enable_i = ($urandom_range(0, 3) != 0);
            bus.p1_enable_i = ($urandom_range(0, 3) != 0);
            bus.p0_write_i = 1'($urandom);
            bus.p1_write_i = 1'($urandom);
            bus.p0_addr_i = $urandom;
            bus.p1_addr_i = $urandom;
            bus.p0_data_i = {8{$urandom}};
            bus.p1_data_i = {8{$urandom}};
            bus.mem_data_i = {8{$urandom}};
            bus.mem_ack_i = ($urandom_range(0, 2) == 0);
            probe("rand");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory byte-address width.
REQ-002 SHALL have parameter LINE_W, default 256, cache-line data width.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have ports p0_enable_i, p0_write_i (input, 1), p0_addr_i (input, ADDR_W) and p0_data_i (input, LINE_W), the requester-0 (dcache) request.
REQ-006 SHALL have ports p0_data_o (output, LINE_W) and p0_ack_o (output, 1), the requester-0 response.
REQ-007 SHALL have ports p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_data_o and p1_ack_o, the requester-1 (icache) set, with widths as for requester 0.
REQ-008 SHALL have ports mem_enable_o, mem_write_o (output, 1), mem_addr_o (output, ADDR_W) and mem_data_o (output, LINE_W), the shared data-memory request.
REQ-009 SHALL have ports mem_data_i (input, LINE_W) and mem_ack_i (input, 1), the data-memory response.
REQ-010 SHALL have port grant_o, output, 2 bits, a one-hot current owner that is 00 when idle.

Function
REQ-011 SHALL implement the FSM states IDLE, BUSY0 and BUSY1.
REQ-012 In IDLE, with any pX_enable_i high, SHALL select a winner per REQ-018 and register BUSYX at the next edge; with no request it SHALL stay in IDLE.
REQ-013 In BUSYX, SHALL drive mem_enable_o = pX_enable_i and mem_write_o/mem_addr_o/mem_data_o = pX_* combinationally; in IDLE it SHALL drive all mem_* outputs to 0.
REQ-014 Latency: a request sampled in IDLE at edge N SHALL be visible on mem_enable_o in the cycle after edge N, with no added memory latency.
REQ-015 In BUSYX, SHALL drive pX_ack_o = mem_ack_i; the non-owner ack SHALL be 0 always, and the ack SHALL be 0 in IDLE.
REQ-016 SHALL broadcast p0_data_o = p1_data_o = mem_data_i unconditionally, so that qualification is by ack only.
REQ-017 In BUSYX, on mem_ack_i=1 or pX_enable_i=0 (abort), SHALL go to IDLE at the next edge; this gives one mandatory idle cycle between transactions so the owner can drop or change its request (e.g. writeback then refill).
REQ-018 Simultaneous requests in IDLE SHALL be resolved per the Configuration section; a lone requester SHALL always win.
REQ-019 A request arriving during BUSY of the other port SHALL be held pending (the requester keeps enable high) and served from the next IDLE.
REQ-020 Changes to the owner's write/addr/data mid-BUSY SHALL pass through unchanged; the arbiter SHALL NOT latch them.
REQ-021 grant_o SHALL be 01 in BUSY0, 10 in BUSY1 and 00 in IDLE.

Reset
REQ-022 While rst_i=1 at an edge, SHALL enter IDLE and set the round-robin pointer to favour p0.
REQ-023 During and after reset, all outputs except pX_data_o SHALL be 0; pX_data_o SHALL still follow mem_data_i.
REQ-024 Reset mid-BUSY SHALL abandon the transaction and SHALL generate no ack.

Configuration
REQ-025 With ARB_ROUND_ROBIN_EN defined, SHALL keep a 1-bit last-owner register updated on every BUSY exit, and ties SHALL go to the port that was not the last owner.
REQ-026 Without ARB_ROUND_ROBIN_EN, ties SHALL go to p0 (fixed priority), with no pointer register present.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE=2'd0, BUSY0=2'd1, BUSY1=2'd2) and the default ADDR_W/LINE_W constants.
REQ-028 SHALL be a single module with no sub-module; the tie-break logic is small enough to remain inline.

Verification
REQ-029 Bench SHALL cover: p0 read of addr 0x0000_0400 alone -> grant_o=01 next cycle, mem_addr_o=0x400, p0_ack_o pulses with mem_ack_i, p1_ack_o stays 0.
REQ-030 Bench SHALL cover: p0 and p1 raised in the same cycle, RR build -> p0 served first, then p1 after one IDLE cycle; a second tie -> p1 first.
REQ-031 Bench SHALL cover: the same tie, fixed-priority build, repeated 3 times -> p0 wins every tie.
REQ-032 Bench SHALL cover: p0 writeback (write=1, data 0xA5..A5) acked, then p0 keeps enable high with write=0 -> refill granted after one IDLE cycle, with mem_data_o=0xA5..A5 during the writeback.
REQ-033 Bench SHALL cover: rst_i=1 for 1 cycle mid-BUSY1 -> grant_o=00, mem_enable_o=0 next cycle, and no p1_ack_o even when mem_ack_i=1.
REQ-034 Bench SHALL cover: the owner drops enable in BUSY0 without ack -> IDLE next edge, and a pending p1 is then granted.
